// File: rtl/cache_pkg.sv
// Shared cache-controller types and helpers used by the read and write control FSMs.
// Holds the read-FSM state encoding, default geometry and block-address alignment.
package cache_pkg;

  localparam int DEF_ADDR_W        = 32;
  localparam int DEF_WORDS_PER_BLK = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_FILL = 3'd3,
    UPDATE    = 3'd4,
    RESPOND   = 3'd5
  } rd_state_t;

  // Single-bit control outputs of the read FSM, grouped so they can be cleared in one line.
  typedef struct packed {
    logic stall;
    logic hit;
    logic miss;
    logic mem_req;
    logic refill_we;
    logic upd_entry;
    logic data_valid;
  } rd_ctrl_t;

  // Clears the word-offset and byte-offset bits (off_w word bits plus 2 byte bits).
  function automatic logic [63:0] block_align(input logic [63:0] addr, input int off_w);
    return addr & ~((64'd1 << (off_w + 2)) - 64'd1);
  endfunction

endpackage

// File: rtl/refill_beat_counter.sv
// Counts refill beats within one cache block; shared by the read- and write-miss paths.
// last_beat flags that the current count addresses the final word of the block.
module refill_beat_counter #(
  parameter  int WORDS_PER_BLK = 4,
  localparam int OFF_W         = $clog2(WORDS_PER_BLK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [OFF_W-1:0] beat_cnt,
  output logic             last_beat
);

  logic [OFF_W-1:0] cnt_q, cnt_d;

  assign last_beat = (cnt_q == OFF_W'(WORDS_PER_BLK - 1));
  assign beat_cnt  = cnt_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || (inc && last_beat)) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + OFF_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/read_ctrl_fsm.sv
// Read-side control FSM of the direct-mapped data cache: lookup, block refill on miss,
// tag/valid update, then respond. Outputs are decoded combinationally from state and inputs.
module read_ctrl_fsm
  import cache_pkg::*;
#(
  parameter  int ADDR_W        = DEF_ADDR_W,
  parameter  int WORDS_PER_BLK = DEF_WORDS_PER_BLK,
  localparam int OFF_W         = $clog2(WORDS_PER_BLK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_busy,
  input  logic              tag_match,
  input  logic              valid_out,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  output logic              rd_stall,
  output logic              rd_cache_hit,
  output logic              rd_cache_miss,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              refill_we,
  output logic [OFF_W-1:0]  refill_word_idx,
  output logic              upd_entry,
  output logic              rd_data_valid
);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  rd_ctrl_t          ctrl;
  logic              beat_clr, beat_inc, last_beat;
  logic [OFF_W-1:0]  beat_cnt;

  refill_beat_counter #(.WORDS_PER_BLK(WORDS_PER_BLK)) u_beat_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (beat_clr),
    .inc       (beat_inc),
    .beat_cnt  (beat_cnt),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    beat_clr        = 1'b0;
    beat_inc        = 1'b0;
    ctrl            = '0;
    refill_word_idx = '0;
    mem_rd_addr     = ADDR_W'(block_align(64'(addr_q), OFF_W));

    case (state_q)
      IDLE: begin
        // A pending load stalls the CPU even while the write FSM holds it off.
        if (rd_en) begin
          ctrl.stall = 1'b1;
          if (!wr_busy) begin
            addr_d  = rd_addr;
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        ctrl.stall = 1'b1;
        if (tag_match && valid_out) begin
          ctrl.hit = 1'b1;
          state_d  = RESPOND;
        end else begin
          ctrl.miss = 1'b1;
          state_d   = MISS_REQ;
        end
      end
      MISS_REQ: begin
        ctrl.stall   = 1'b1;
        ctrl.miss    = 1'b1;
        ctrl.mem_req = 1'b1;
        if (mem_rd_ack) begin
          beat_clr = 1'b1;
          state_d  = MISS_FILL;
        end
      end
      MISS_FILL: begin
        ctrl.stall = 1'b1;
        ctrl.miss  = 1'b1;
        if (mem_rd_valid) begin
          ctrl.refill_we  = 1'b1;
          refill_word_idx = beat_cnt;
          beat_inc        = 1'b1;
          if (last_beat) begin
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        ctrl.stall     = 1'b1;
        ctrl.miss      = 1'b1;
        ctrl.upd_entry = 1'b1;
        state_d        = RESPOND;
      end
      RESPOND: begin
        ctrl.data_valid = 1'b1;
        state_d         = IDLE;
      end
      default: begin
        mem_rd_addr = '0;
        state_d     = IDLE;
      end
    endcase

    // Outputs read as idle throughout the reset cycle, whatever state is being left.
    if (!rst_n) begin
      ctrl            = '0;
      refill_word_idx = '0;
      mem_rd_addr     = '0;
    end
  end

  assign rd_stall      = ctrl.stall;
  assign rd_cache_hit  = ctrl.hit;
  assign rd_cache_miss = ctrl.miss;
  assign mem_rd_req    = ctrl.mem_req;
  assign refill_we     = ctrl.refill_we;
  assign upd_entry     = ctrl.upd_entry;
  assign rd_data_valid = ctrl.data_valid;

endmodule

// File: tb/tb_read_ctrl_fsm.sv
// Self-checking bench for read_ctrl_fsm: each load is expanded into a cycle timeline
// from the documented latency rules and compared output-by-output every cycle.
module tb_read_ctrl_fsm;

  localparam int AW  = 32;
  localparam int WPB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          wr_busy, tag_match, valid_out, mem_rd_ack, mem_rd_valid;
  logic          rd_stall, rd_cache_hit, rd_cache_miss, mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          refill_we;
  logic [1:0]    refill_word_idx;
  logic          upd_entry, rd_data_valid;

  typedef struct packed {
    logic       stall;
    logic       hit;
    logic       miss;
    logic       req;
    logic       we;
    logic [1:0] idx;
    logic       upd;
    logic       dv;
  } obs_t;

  int n_vec      = 0;
  int n_err      = 0;
  int cyc        = 0;
  int stall_seen = 0;

  read_ctrl_fsm #(.ADDR_W(AW), .WORDS_PER_BLK(WPB)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .wr_busy         (wr_busy),
    .tag_match       (tag_match),
    .valid_out       (valid_out),
    .mem_rd_ack      (mem_rd_ack),
    .mem_rd_valid    (mem_rd_valid),
    .rd_stall        (rd_stall),
    .rd_cache_hit    (rd_cache_hit),
    .rd_cache_miss   (rd_cache_miss),
    .mem_rd_req      (mem_rd_req),
    .mem_rd_addr     (mem_rd_addr),
    .refill_we       (refill_we),
    .refill_word_idx (refill_word_idx),
    .upd_entry       (upd_entry),
    .rd_data_valid   (rd_data_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  // Inputs are set just after a falling edge; outputs are sampled 1 time unit later.
  task automatic step(input obs_t exp, input bit chk_addr, input logic [AW-1:0] exp_addr);
    obs_t got;
    #1;
    got = {rd_stall, rd_cache_hit, rd_cache_miss, mem_rd_req, refill_we,
           refill_word_idx, upd_entry, rd_data_valid};
    check("outputs", 32'(got), 32'(exp));
    if (chk_addr) check("mem_rd_addr", mem_rd_addr, exp_addr);
    if (got.stall === 1'b1) stall_seen++;
    @(negedge clk);
    cyc++;
  endtask

  // Randomises every input the DUT must ignore in the coming cycle.
  task automatic noise();
    tag_match    = 1'($urandom_range(0, 1));
    valid_out    = 1'($urandom_range(0, 1));
    mem_rd_ack   = 1'($urandom_range(0, 1));
    mem_rd_valid = 1'($urandom_range(0, 1));
    wr_busy      = 1'($urandom_range(0, 1));
    rd_addr      = $urandom;
  endtask

  // One load: busy cycles of write-FSM blocking, then accept, lookup and either a hit
  // or a refill. gap_mode: 0 back-to-back beats, 1 alternate cycles, 2 random gaps.
  // rst_after > 0 pulses reset right after that many refill beats.
  task automatic run_txn(input logic [AW-1:0] addr, input bit hit, input int ack_wait,
                         input int gap_mode, input int busy, input int rst_after);
    obs_t          e;
    int            gaps[WPB];
    int            gap_sum;
    int            exp_stall;
    int            r;
    logic [AW-1:0] blk;

    blk     = addr & ~AW'(WPB * 4 - 1);
    gap_sum = 0;
    for (int j = 0; j < WPB; j++) begin
      gaps[j] = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((j == 0) ? 0 : 1)
                                                        : $urandom_range(0, 2);
      gap_sum += gaps[j];
    end
    exp_stall  = busy + (hit ? 2 : 4 + ack_wait + WPB + gap_sum);
    stall_seen = 0;

    repeat (busy) begin
      noise(); rd_en = 1'b1; wr_busy = 1'b1;
      e = '0; e.stall = 1'b1; step(e, 1'b0, '0);
    end

    noise(); rd_en = 1'b1; wr_busy = 1'b0; rd_addr = addr;
    e = '0; e.stall = 1'b1; step(e, 1'b0, '0);

    noise();
    if (hit) begin
      tag_match = 1'b1; valid_out = 1'b1;
    end else begin
      r = $urandom_range(0, 2);
      tag_match = (r == 1); valid_out = (r == 2);
    end
    e = '0; e.stall = 1'b1; e.hit = hit; e.miss = !hit; step(e, 1'b0, '0);

    if (!hit) begin
      for (int k = 0; k <= ack_wait; k++) begin
        noise(); mem_rd_ack = (k == ack_wait);
        e = '0; e.stall = 1'b1; e.miss = 1'b1; e.req = 1'b1; step(e, 1'b1, blk);
      end
      for (int j = 0; j < WPB; j++) begin
        repeat (gaps[j]) begin
          noise(); mem_rd_valid = 1'b0;
          e = '0; e.stall = 1'b1; e.miss = 1'b1; step(e, 1'b1, blk);
        end
        noise(); mem_rd_valid = 1'b1;
        e = '0; e.stall = 1'b1; e.miss = 1'b1; e.we = 1'b1; e.idx = 2'(j);
        step(e, 1'b1, blk);
        if (rst_after == j + 1) begin
          noise(); rd_en = 1'b0; rst_n = 1'b0;
          e = '0; step(e, 1'b1, '0);
          noise(); rst_n = 1'b1;
          e = '0; step(e, 1'b0, '0);
          return;
        end
      end
      noise();
      e = '0; e.stall = 1'b1; e.miss = 1'b1; e.upd = 1'b1; step(e, 1'b0, '0);
    end

    noise(); rd_en = 1'($urandom_range(0, 1));
    e = '0; e.dv = 1'b1; step(e, 1'b0, '0);

    // A load offered during RESPOND must not have been taken: this cycle is idle.
    noise(); rd_en = 1'b0;
    e = '0; step(e, 1'b0, '0);

    check("stall_cycles", 32'(stall_seen), 32'(exp_stall));
  endtask

  initial begin
    obs_t e;
    rst_n = 1'b0; rd_en = 1'b1;
    noise();
    @(negedge clk);
    repeat (2) begin
      noise(); rd_en = 1'b1;
      e = '0; step(e, 1'b1, '0);
    end
    rst_n = 1'b1;

    run_txn(32'h0000_0040, 1'b1, 0, 0, 0, 0);  // plain hit
    run_txn(32'h0000_1234, 1'b0, 3, 0, 0, 0);  // miss, ack wait 3, back-to-back beats
    run_txn(32'h0000_2468, 1'b0, 1, 1, 0, 0);  // miss with alternating beats
    run_txn(32'h0000_0080, 1'b1, 0, 0, 5, 0);  // blocked by write FSM for 5 cycles
    run_txn(32'h0000_ABC8, 1'b0, 2, 2, 1, 0);  // noisy inputs during refill
    run_txn(32'h0000_5550, 1'b0, 1, 0, 0, 2);  // reset after second beat
    run_txn(32'h0000_5550, 1'b0, 0, 0, 0, 0);  // fresh miss refills 0..3

    for (int i = 0; i < 60; i++) begin
      run_txn($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
              $urandom_range(0, 2), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0) ? $urandom_range(1, WPB - 1) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
